// File: rtl/onchip_ram_pipe.sv
// On-chip single-port RAM slave with byte-enabled writes, a power-up
// zero-fill sequencer and a clock-enabled read pipeline of 1 or 2 stages.
module onchip_ram_pipe #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 12,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic                  chipselect,
  input  logic                  clken,
  input  logic                  read,
  input  logic                  write,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic                  waitrequest
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic                acc, rd_acc, wr_acc, clr_we;
  logic [ADDR_W-1:0]   waddr;
  logic [NB-1:0]       wbe;
  logic [DATA_W-1:0]   wdat;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [READ_LATENCY:1] vld_pipe;

  // Reset is folded in so nothing is accepted in the reset cycle itself.
  assign waitrequest = reset | (state == S_CLEAR);
  assign acc    = chipselect & (read | write) & ~waitrequest & clken;
  assign wr_acc = acc & write;
  assign rd_acc = acc & read & ~write;  // read+write collapses to a write
  assign clr_we = ~reset & (state == S_CLEAR);

  // Single write port shared by the clear sequencer and bus writes.
  always_comb begin
    waddr = address;
    wbe   = wr_acc ? byteenable : '0;
    wdat  = writedata;
    if (clr_we) begin
      waddr = clr_cnt;
      wbe   = '1;
      wdat  = '0;
    end
  end

  // Byte-enabled RAM write; left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (wbe[i]) mem[waddr][8*i +: 8] <= wdat[8*i +: 8];
  end

  // CLEAR/RUN sequencer: walks clr_cnt over every word, then opens the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == '1) state <= S_RUN;
    end
  end

  // Read valid shift register; frozen while clken is low, flushed on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (clken) begin
      vld_pipe[1] <= rd_acc;
      for (int i = 2; i <= READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Gated by reset too so a read caught by reset never shows up.
  assign readdatavalid = vld_pipe[READ_LATENCY] & clken & ~reset;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      // RAM output register doubles as readdata; updates only on a read.
      always_ff @(posedge clk) begin
        if (reset)       readdata <= '0;
        else if (rd_acc) readdata <= mem[address];
      end
    end else begin : g_lat2
      logic [DATA_W-1:0] ram_q;

      // RAM output register, loaded on read acceptance.
      always_ff @(posedge clk) begin
        if (rd_acc) ram_q <= mem[address];
      end

      // Output stage: loads only when a result advances into it.
      always_ff @(posedge clk) begin
        if (reset)                     readdata <= '0;
        else if (clken && vld_pipe[1]) readdata <= ram_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_onchip_ram_pipe.sv
// Directed bench: dut (latency 1, clear on reset) and dut2 (latency 2,
// contents retained across reset).
module tb_onchip_ram_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, chipselect, clken, read, write;
  logic [11:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata, readdata;
  logic        readdatavalid, waitrequest;

  logic        b_reset, b_chipselect, b_clken, b_read, b_write;
  logic [11:0] b_address;
  logic [3:0]  b_byteenable;
  logic [31:0] b_writedata, b_readdata;
  logic        b_readdatavalid, b_waitrequest;

  onchip_ram_pipe #(.DATA_W(32), .ADDR_W(12), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .clken(clken), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest));

  onchip_ram_pipe #(.DATA_W(32), .ADDR_W(12), .READ_LATENCY(2), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .reset(b_reset), .address(b_address), .byteenable(b_byteenable),
    .chipselect(b_chipselect), .clken(b_clken), .read(b_read), .write(b_write),
    .writedata(b_writedata), .readdata(b_readdata), .readdatavalid(b_readdatavalid),
    .waitrequest(b_waitrequest));

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        cs, rd, wr;
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1;
    address = '0; byteenable = '0; writedata = '0;
  endtask

  // Called right after reset is released; counts cycles until the port opens.
  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (waitrequest && n < 5000) begin
      tick;
      n++;
    end
    chk(name, n, 4096);
  endtask

  task automatic acc1(input logic rd, input logic wr, input logic [11:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
    chipselect = 1'b1; read = rd; write = wr; address = a;
    byteenable = be; writedata = wd;
  endtask

  initial begin
    logic [31:0] last;
    logic [31:0] exp2 [3];

    //                cs    rd    wr    addr     be     wdata         ev    edata
    tv[0]  = '{1'b1, 1'b1, 1'b0, 12'h000, 4'h0, 32'h0,        1'b1, 32'h00000000};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 12'h7FF, 4'h0, 32'h0,        1'b1, 32'h00000000};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 12'hFFF, 4'h0, 32'h0,        1'b1, 32'h00000000};
    tv[3]  = '{1'b1, 1'b0, 1'b1, 12'h010, 4'hF, 32'h11223344, 1'b0, 32'h0};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 12'h010, 4'h5, 32'hAABBCCDD, 1'b0, 32'h0};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 12'h010, 4'h0, 32'h0,        1'b1, 32'h11BB33DD};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 12'h011, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 12'h011, 4'h0, 32'h0,        1'b1, 32'h00000000};
    tv[8]  = '{1'b1, 1'b1, 1'b1, 12'h020, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[9]  = '{1'b1, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
    tv[10] = '{1'b1, 1'b0, 1'b1, 12'h7FF, 4'h8, 32'h12345678, 1'b0, 32'h0};
    tv[11] = '{1'b1, 1'b1, 1'b0, 12'h7FF, 4'h0, 32'h0,        1'b1, 32'h12000000};
    tv[12] = '{1'b0, 1'b0, 1'b1, 12'h020, 4'hF, 32'h00000000, 1'b0, 32'h0};
    tv[13] = '{1'b1, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0,        1'b1, 32'hDEADBEEF};
    tv[14] = '{1'b0, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0,        1'b0, 32'h0};
    tv[15] = '{1'b1, 1'b0, 1'b1, 12'hFFF, 4'h3, 32'hCAFEF00D, 1'b0, 32'h0};
    tv[16] = '{1'b1, 1'b1, 1'b0, 12'hFFF, 4'h0, 32'h0,        1'b1, 32'h0000F00D};
    tv[17] = '{1'b1, 1'b1, 1'b0, 12'h010, 4'h0, 32'h0,        1'b1, 32'h11BB33DD};

    idle;
    reset = 1'b1;
    b_reset = 1'b1; b_chipselect = 1'b0; b_clken = 1'b1; b_read = 1'b0; b_write = 1'b0;
    b_address = '0; b_byteenable = '0; b_writedata = '0;
    tick;
    chk("rst readdata", readdata, 32'h0);
    chk("rst readdatavalid", readdatavalid, 1'b0);
    chk("rst waitrequest", waitrequest, 1'b1);
    chk("rst2 waitrequest", b_waitrequest, 1'b1);
    chk("rst2 readdata", b_readdata, 32'h0);

    // dut2: no clear, port opens as soon as reset drops
    b_reset = 1'b0;
    #1;
    chk("nc waitrequest low", b_waitrequest, 1'b0);
    exp2[0] = 32'hA1A1A1A1; exp2[1] = 32'hB2B2B2B2; exp2[2] = 32'hC3C3C3C3;
    for (int i = 0; i < 3; i++) begin
      b_chipselect = 1'b1; b_write = 1'b1; b_byteenable = 4'hF;
      b_address = 12'(i + 1); b_writedata = exp2[i];
      tick;
    end
    b_write = 1'b0;
    // back-to-back reads, results two cycles after acceptance
    last = 32'h0;
    for (int i = 0; i < 5; i++) begin
      b_read = (i < 3);
      b_address = 12'(i + 1);
      tick;
      chk($sformatf("lat2 valid %0d", i), b_readdatavalid, (i >= 1 && i <= 3));
      if (i >= 1 && i <= 3) last = exp2[i-1];
      chk($sformatf("lat2 data %0d", i), b_readdata, last);
    end
    b_read = 1'b0; b_chipselect = 1'b0;
    // contents survive reset
    b_reset = 1'b1;
    tick;
    chk("lat2 rst readdata", b_readdata, 32'h0);
    b_reset = 1'b0;
    b_chipselect = 1'b1; b_read = 1'b1; b_address = 12'h002;
    tick;
    b_read = 1'b0; b_chipselect = 1'b0;
    chk("keep valid early", b_readdatavalid, 1'b0);
    tick;
    chk("keep valid", b_readdatavalid, 1'b1);
    chk("keep data", b_readdata, 32'hB2B2B2B2);

    // dut: zero fill
    reset = 1'b0;
    wait_clear("clear length");

    last = 32'h0;
    for (int i = 0; i < NV; i++) begin
      chipselect = tv[i].cs; read = tv[i].rd; write = tv[i].wr;
      address = tv[i].a; byteenable = tv[i].be; writedata = tv[i].wd;
      tick;
      chk($sformatf("vec%0d valid", i), readdatavalid, tv[i].ev);
      if (tv[i].ev) last = tv[i].ed;
      chk($sformatf("vec%0d data", i), readdata, last);
    end
    idle;

    // read result stalled by clken low for three cycles
    acc1(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
    tick;
    idle;
    clken = 1'b0;
    #1;
    chk("stall c1", readdatavalid, 1'b0);
    tick;
    chk("stall c2", readdatavalid, 1'b0);
    tick;
    chk("stall c3", readdatavalid, 1'b0);
    tick;
    clken = 1'b1;
    #1;
    chk("stall release valid", readdatavalid, 1'b1);
    chk("stall release data", readdata, 32'h11BB33DD);
    tick;
    chk("stall single pulse", readdatavalid, 1'b0);

    // requests entering with clken low are ignored
    acc1(1'b0, 1'b1, 12'h010, 4'hF, 32'h0);
    clken = 1'b0;
    tick;
    acc1(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
    clken = 1'b0;
    tick;
    idle;
    #1;
    chk("clken0 read dropped", readdatavalid, 1'b0);
    tick;
    chk("clken0 read dropped 2", readdatavalid, 1'b0);
    acc1(1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
    tick;
    idle;
    chk("clken0 write dropped v", readdatavalid, 1'b1);
    chk("clken0 write dropped d", readdata, 32'h11BB33DD);

    // in-flight read killed by reset, then clear restarted mid-way
    acc1(1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
    tick;
    idle;
    reset = 1'b1;
    #1;
    chk("rst kill valid", readdatavalid, 1'b0);
    tick;
    chk("rst kill valid 2", readdatavalid, 1'b0);
    chk("rst kill readdata", readdata, 32'h0);
    chk("rst kill waitrequest", waitrequest, 1'b1);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
        tick;
        if (readdatavalid) seen++;
      end
      chk("rst no late valid", seen, 0);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    wait_clear("clear restart length");
    acc1(1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
    tick;
    idle;
    chk("recleared valid", readdatavalid, 1'b1);
    chk("recleared data", readdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
